// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite constants for the slave-side response path.
package ahblite_pkg;

  localparam int AHB_NPORTS = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [31:0] AHB_IDLE_RDATA = 32'h0000_0000;

  // Keep only the lowest set bit so the stored select is one-hot or zero.
  function automatic logic [AHB_NPORTS-1:0] lowest_one(input logic [AHB_NPORTS-1:0] v);
    logic [AHB_NPORTS-1:0] r;
    r = '0;
    for (int i = AHB_NPORTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers unmapped / disabled-port transfers with a two-cycle ERROR.
//
// state   | meaning
// --------+------------------------------------------------------------
// DS_IDLE | no error pending, zero-wait OKAY (HREADYOUT=1, HRESP=0)
// DS_ERR1 | first ERROR cycle, stalls the master (HREADYOUT=0, HRESP=1)
// DS_ERR2 | second ERROR cycle, completes it (HREADYOUT=1, HRESP=1)
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       hsel_none,
  output logic       ds_hreadyout,
  output logic       ds_hresp
);

  ds_state_e state_q;
  logic      hreadyout_q;
  logic      hresp_q;
  logic      trans_active;
  logic      start_err;

  // Only NONSEQ/SEQ accepted in an address phase open an ERROR; IDLE/BUSY get OKAY.
  always_comb begin
    trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    start_err    = HREADY & trans_active & hsel_none;
  end

  // State and registered outputs; ERR2 may chain straight into a new ERR1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= DS_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (start_err) begin
            state_q     <= DS_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        DS_ERR1: begin
          state_q     <= DS_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        DS_ERR2: begin
          if (start_err) begin
            state_q     <= DS_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= DS_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ds_hreadyout = hreadyout_q;
  assign ds_hresp     = hresp_q;

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response mux: latches the data-phase owner and steers its response to the master.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter logic Port0_en = 1'b1,
  parameter logic Port1_en = 1'b0,
  parameter logic Port2_en = 1'b0,
  parameter logic Port3_en = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [AHB_NPORTS-1:0] effsel;
  logic [AHB_NPORTS-1:0] sel_d;
  logic [AHB_NPORTS-1:0] sel_q;
  logic                  hsel_none;
  logic                  ds_hreadyout;
  logic                  ds_hresp;

  // Disabled ports look unmapped; overlapping selects resolve to the lowest index.
  always_comb begin
    effsel    = {P3_HSEL & Port3_en, P2_HSEL & Port2_en, P1_HSEL & Port1_en, P0_HSEL & Port0_en};
    hsel_none = ~|effsel;
    sel_d     = HREADY ? lowest_one(effsel) : sel_q;
  end

  // Data-phase owner, frozen while the current data phase is stalled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HREADY       (HREADY),
    .HTRANS       (HTRANS),
    .hsel_none    (hsel_none),
    .ds_hreadyout (ds_hreadyout),
    .ds_hresp     (ds_hresp)
  );

  // Combinational response steering; no wait states added for mapped slaves.
  always_comb begin
    HREADYOUT = ds_hreadyout;
    HRESP     = ds_hresp;
    HRDATA    = AHB_IDLE_RDATA;
    if (sel_q[0]) begin
      HREADYOUT = P0_HREADYOUT;
      HRESP     = P0_HRESP;
      HRDATA    = P0_HRDATA;
    end else if (sel_q[1]) begin
      HREADYOUT = P1_HREADYOUT;
      HRESP     = P1_HRESP;
      HRDATA    = P1_HRDATA;
    end else if (sel_q[2]) begin
      HREADYOUT = P2_HREADYOUT;
      HRESP     = P2_HRESP;
      HRDATA    = P2_HRDATA;
    end else if (sel_q[3]) begin
      HREADYOUT = P3_HREADYOUT;
      HRESP     = P3_HRESP;
      HRDATA    = P3_HRDATA;
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux: per-cycle expectations queued, checked by a monitor.
module tb_ahblite_slave_mux;

  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] D1 = 32'h1111_2222;
  localparam logic [31:0] D2 = 32'h3333_4444;
  localparam logic [31:0] D3 = 32'h5555_6666;
  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_BUSY = 2'b01;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [1:0]  T_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [3:0]  hsel;
  logic [3:0]  prdy;
  logic [3:0]  presp;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 HCLK = ~HCLK;

  // System HREADY is this block's own HREADYOUT.
  assign HREADY = HREADYOUT;

  ahblite_slave_mux #(
    .Port0_en (1'b1),
    .Port1_en (1'b1),
    .Port2_en (1'b1),
    .Port3_en (1'b0)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HREADY       (HREADY),
    .HTRANS       (HTRANS),
    .P0_HSEL      (hsel[0]),
    .P1_HSEL      (hsel[1]),
    .P2_HSEL      (hsel[2]),
    .P3_HSEL      (hsel[3]),
    .P0_HREADYOUT (prdy[0]),
    .P1_HREADYOUT (prdy[1]),
    .P2_HREADYOUT (prdy[2]),
    .P3_HREADYOUT (prdy[3]),
    .P0_HRESP     (presp[0]),
    .P1_HRESP     (presp[1]),
    .P2_HRESP     (presp[2]),
    .P3_HRESP     (presp[3]),
    .P0_HRDATA    (D0),
    .P1_HRDATA    (D1),
    .P2_HRDATA    (D2),
    .P3_HRDATA    (D3),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA)
  );

  // One bus cycle: drive inputs just after the edge and queue the response expected this cycle.
  // rst_op: 0 none, 1 assert reset before the sample point, 2 release reset after it.
  task automatic cyc(input logic [1:0] tr, input logic [3:0] sel, input logic [3:0] rdy,
                     input logic [3:0] rsp, input int rst_op, input logic er, input logic ep,
                     input logic [31:0] ed, input string name);
    exp_t e;
    @(posedge HCLK);
    #1;
    HTRANS = tr;
    hsel   = sel;
    prdy   = rdy;
    presp  = rsp;
    e.rdy  = er;
    e.resp = ep;
    e.data = ed;
    e.name = name;
    exp_q.push_back(e);
    if (rst_op == 1) begin
      #1 HRESETn = 1'b0;
    end else if (rst_op == 2) begin
      #6 HRESETn = 1'b1;
    end
  endtask

  // Monitor: compare the DUT response mid-cycle against the queued expectation.
  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (HREADYOUT !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
        fails++;
        $display("FAIL %s: got hreadyout=%0b hresp=%0b hrdata=%h, expected hreadyout=%0b hresp=%0b hrdata=%h",
                 e.name, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0;
    HTRANS  = T_IDLE;
    hsel    = 4'h0;
    prdy    = 4'hF;
    presp   = 4'h0;

    // reset state, then release
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 2, 1'b1, 1'b0, 32'h0, "reset_values");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "idle_after_reset");

    // RAMCODE read
    cyc(T_NSEQ, 4'h1, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "p0_addr");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, D0,    "p0_read");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "p0_done");

    // overlapping selects: P0 wins, then P1 alone
    cyc(T_NSEQ, 4'h3, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "prio_addr");
    cyc(T_NSEQ, 4'h2, 4'hF, 4'h0, 0, 1'b1, 1'b0, D0,    "prio_low_wins");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, D1,    "p1_read");

    // slave ERROR passes through untouched
    cyc(T_NSEQ, 4'h4, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "p2err_addr");
    cyc(T_IDLE, 4'h0, 4'hB, 4'h4, 0, 1'b0, 1'b1, D2,    "p2err_cycle1");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h4, 0, 1'b1, 1'b1, D2,    "p2err_cycle2");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "p2err_done");

    // P2 wait states while HSEL wanders; unmapped NONSEQ during the stall is not accepted
    cyc(T_NSEQ, 4'h4, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "wait_addr");
    cyc(T_NSEQ, 4'h0, 4'hB, 4'h0, 0, 1'b0, 1'b0, D2,    "wait_1");
    cyc(T_NSEQ, 4'h1, 4'hB, 4'h0, 0, 1'b0, 1'b0, D2,    "wait_2");
    cyc(T_NSEQ, 4'h8, 4'hB, 4'h0, 0, 1'b0, 1'b0, D2,    "wait_3");
    cyc(T_NSEQ, 4'h1, 4'hF, 4'h0, 0, 1'b1, 1'b0, D2,    "wait_release");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, D0,    "wait_next_p0");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "wait_done");

    // unmapped NONSEQ
    cyc(T_NSEQ, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "unmap_addr");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b0, 1'b1, 32'h0, "unmap_err1");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b1, 32'h0, "unmap_err2");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "unmap_free");

    // disabled port: NONSEQ errors, IDLE/BUSY get zero-wait OKAY
    cyc(T_NSEQ, 4'h8, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "dis_addr");
    cyc(T_IDLE, 4'h8, 4'hF, 4'h0, 0, 1'b0, 1'b1, 32'h0, "dis_err1");
    cyc(T_IDLE, 4'h8, 4'hF, 4'h0, 0, 1'b1, 1'b1, 32'h0, "dis_err2");
    cyc(T_BUSY, 4'h8, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "dis_idle_okay");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "dis_busy_okay");

    // back-to-back unmapped transfers
    cyc(T_NSEQ, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "b2b_addr1");
    cyc(T_SEQ,  4'h0, 4'hF, 4'h0, 0, 1'b0, 1'b1, 32'h0, "b2b_err1a");
    cyc(T_NSEQ, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b1, 32'h0, "b2b_err2a");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b0, 1'b1, 32'h0, "b2b_err1b");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b1, 32'h0, "b2b_err2b");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "b2b_free");

    // mapped transfer accepted during ERR2
    cyc(T_NSEQ, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "err2map_addr");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b0, 1'b1, 32'h0, "err2map_err1");
    cyc(T_NSEQ, 4'h2, 4'hF, 4'h0, 0, 1'b1, 1'b1, 32'h0, "err2map_err2");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, D1,    "err2map_p1");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "err2map_done");

    // async reset during ERR1 aborts the error
    cyc(T_NSEQ, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "rst_err_addr");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 1, 1'b1, 1'b0, 32'h0, "rst_err_async");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 2, 1'b1, 1'b0, 32'h0, "rst_err_held");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "rst_err_aborted");

    // async reset clears a mapped data phase
    cyc(T_NSEQ, 4'h1, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "rst_sel_addr");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 1, 1'b1, 1'b0, 32'h0, "rst_sel_async");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 2, 1'b1, 1'b0, 32'h0, "rst_sel_held");
    cyc(T_IDLE, 4'h0, 4'hF, 4'h0, 0, 1'b1, 1'b0, 32'h0, "rst_sel_cleared");

    repeat (3) @(posedge HCLK);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux.md
# ahblite_slave_mux

Response-side counterpart of the AHB-Lite address decoder: it takes the per-port HSEL lines the decoder produces, registers which port owns the current data phase, and steers that port's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master. It contains a built-in default slave that answers any transfer to unmapped or disabled address space with the standard two-cycle ERROR response. It sits between the four slave ports (RAMCODE, RAMDATA, WaterLight, UART) and the master's response inputs.

## Interface
- Port0_en, 1, RAMCODE port enable; a disabled port's HSEL is ignored.
- Port1_en, 0, RAMDATA port enable.
- Port2_en, 0, WaterLight port enable.
- Port3_en, 0, UART port enable.

- HCLK  in  1  system clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HREADY  in  1  system HREADY, fed back from this block's HREADYOUT; qualifies address phases.
- HTRANS  in  2  master transfer type; bit 1 set means NONSEQ/SEQ.
- P0_HSEL..P3_HSEL  in  1 each  address-phase selects from the decoder.
- P0_HREADYOUT..P3_HREADYOUT  in  1 each  slave ready.
- P0_HRESP..P3_HRESP  in  1 each  slave response; 1 means ERROR.
- P0_HRDATA..P3_HRDATA  in  32 each  slave read data.
- HREADYOUT  out  1  muxed ready to the master.
- HRESP  out  1  muxed response to the master.
- HRDATA  out  32  muxed read data to the master.

## Operation
- Effective select: effsel[i] = Pi_HSEL & Porti_en.
- Data-phase select register sel_q (4 bits): loaded with effsel when HREADY=1 and held while HREADY=0. Reset value is 4'b0000.
- More than one effsel bit high: the lowest index wins, and only that bit is stored, so sel_q is always one-hot or zero.
- Output mux when sel_q[i]=1: HREADYOUT=Pi_HREADYOUT, HRESP=Pi_HRESP, HRDATA=Pi_HRDATA.
- Output mux when sel_q=0: outputs come from the default slave, with HRDATA=32'h0000_0000.
- Default slave FSM states:
  - DS_IDLE: HREADYOUT=1, HRESP=0.
  - DS_ERR1: HREADYOUT=0, HRESP=1.
  - DS_ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - DS_IDLE -> DS_ERR1 when HREADY=1, HTRANS[1]=1 and effsel=0.
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 when HREADY=1, HTRANS[1]=1 and effsel=0; otherwise DS_ERR2 -> DS_IDLE.
- IDLE or BUSY transfers to unmapped space get a zero-wait OKAY: the FSM stays in DS_IDLE.
- A transfer to an enabled port during DS_ERR2 loads sel_q normally, and the FSM returns to DS_IDLE.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM in DS_IDLE.
- Reset asserted mid-transfer (any state): all outputs return to reset values immediately; no partial ERROR is completed.

## Timing
- Address phase at cycle N (HREADY=1) selects the response source for the data phase starting at cycle N+1.
- Output path is combinational from sel_q, the FSM and the slave inputs. The block adds zero wait states for mapped slaves.
- Slave wait states pass straight through. sel_q is frozen while the selected slave holds HREADYOUT=0, even if HSEL/HTRANS change.
- Unmapped NONSEQ at cycle N: cycle N+1 gives HREADYOUT=0/HRESP=1; cycle N+2 gives HREADYOUT=1/HRESP=1; cycle N+3 is free.
- Back-to-back unmapped transfers (the second address presented in DS_ERR2) produce repeated two-cycle ERRORs with no OKAY gap.
- Slave ERROR passes through unchanged: the slave owns the two-cycle sequence and this block does not re-time it.

## Structure
- Shared package ahblite_pkg holds:
  - AHB_NPORTS=4;
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - default-slave state encoding (DS_IDLE=2'd0, DS_ERR1=2'd1, DS_ERR2=2'd2);
  - AHB_IDLE_RDATA=32'h0.
- Sub-module ahblite_default_slave (HCLK, HRESETn, HREADY, HTRANS, hsel_none -> ds_hreadyout, ds_hresp) holds the FSM. Top level keeps sel_q, priority logic and the output mux.

## Test plan
- Reset: HRESETn low mid-cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; the ERROR sequence is aborted after release.
- RAMCODE read: HADDR 0x0000_0010 with NONSEQ, P0_HRDATA=32'hDEAD_BEEF -> next cycle HRDATA=32'hDEAD_BEEF, HREADYOUT=1, HRESP=0.
- Wait states: P2 enabled and selected, P2_HREADYOUT low for 3 cycles while HSEL changes to P0 -> output follows P2 for all 3 cycles; sel_q switches only after ready.
- Unmapped access: NONSEQ with all HSEL=0 -> next cycle 0/1, then 1/1 (HREADYOUT/HRESP), then OKAY idle.
- Disabled port: Port3_en=0, P3_HSEL=1, NONSEQ -> two-cycle ERROR; an IDLE transfer with the same select -> zero-wait OKAY.
- Back-to-back: an unmapped NONSEQ is presented during DS_ERR2 -> ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between.
